// File: rtl/resp_data_serializer_pkg.sv
// Shared definitions for the SPI response path: frame sizing, FSM states and
// the instruction codes also decoded by the command buffer.
package resp_data_serializer_pkg;

  localparam int unsigned RESP_N_DATA_BYTES = 8;
  localparam int unsigned RESP_FRAME_LEN    = RESP_N_DATA_BYTES + 2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } resp_state_e;

  localparam logic [7:0] INSTR_00 = 8'h00;
  localparam logic [7:0] INSTR_01 = 8'h01;
  localparam logic [7:0] INSTR_02 = 8'h02;
  localparam logic [7:0] INSTR_03 = 8'h03;
  localparam logic [7:0] INSTR_04 = 8'h04;
  localparam logic [7:0] INSTR_05 = 8'h05;
  localparam logic [7:0] INSTR_06 = 8'h06;
  localparam logic [7:0] INSTR_07 = 8'h07;
  localparam logic [7:0] INSTR_08 = 8'h08;
  localparam logic [7:0] INSTR_09 = 8'h09;
  localparam logic [7:0] INSTR_0A = 8'h0A;
  localparam logic [7:0] INSTR_0B = 8'h0B;
  localparam logic [7:0] INSTR_MAX = INSTR_0B;

endpackage

// File: rtl/resp_data_serializer.sv
// Frames {instr, payload MSB-first, XOR checksum} and offers it one byte at a
// time to the SPI TX path with a valid/ack handshake.
module resp_data_serializer
  import resp_data_serializer_pkg::*;
#(
  parameter int unsigned N_DATA_BYTES = RESP_N_DATA_BYTES
) (
  input  logic                      sysClk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [7:0]                resp_instr,
  input  logic [8*N_DATA_BYTES-1:0] resp_data,
  input  logic                      abort,
  output logic [7:0]                byte_out,
  output logic                      byte_valid,
  input  logic                      byte_ack,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned IDX_W  = $clog2(N_DATA_BYTES + 2);
  localparam int unsigned DATA_W = 8 * N_DATA_BYTES;
  localparam logic [IDX_W-1:0] IDX_CHK  = IDX_W'(N_DATA_BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DATA_BYTES + 1);

  resp_state_e       state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [7:0]        byte_q,  byte_d;
  logic [7:0]        chk_q,   chk_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic              done_q,  done_d;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    chk_d   = chk_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      byte_d  = '0;
      chk_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            state_d = SEND;
            shift_d = resp_data;
            byte_d  = resp_instr;
            chk_d   = '0;
            idx_d   = '0;
          end
        end
        SEND: begin
          if (byte_ack) begin
            if (idx_q == IDX_LAST) begin
              state_d = IDLE;
              done_d  = 1'b1;
              chk_d   = '0;
              idx_d   = '0;
            end else begin
              // Accumulate the byte just accepted; the checksum slot sends the running XOR.
              chk_d = chk_q ^ byte_q;
              idx_d = idx_q + 1'b1;
              if (idx_q == IDX_CHK) begin
                byte_d = chk_q ^ byte_q;
              end else begin
                byte_d  = shift_q[DATA_W-1 -: 8];
                shift_d = shift_q << 8;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sysClk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      byte_q  <= '0;
      chk_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      chk_q   <= chk_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign byte_out   = byte_q;
  assign byte_valid = (state_q == SEND);
  assign busy       = (state_q == SEND);
  assign done       = done_q;

endmodule
